// File: rtl/fetch_realigner_if.sv
// Handshake bundle between the fetch FIFO read port, the realigner and the decoder.
interface fetch_realigner_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_err;
  logic        in_rdy;
  logic        out_valid;
  logic        out_rdy;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_comp;
  logic        out_err;

  modport slave (
    input  in_valid, in_data, in_err, out_rdy,
    output in_rdy, out_valid, out_instr, out_pc, out_is_comp, out_err
  );

  modport master (
    output in_valid, in_data, in_err, out_rdy,
    input  in_rdy, out_valid, out_instr, out_pc, out_is_comp, out_err
  );
endinterface

// File: rtl/fetch_realigner.sv
// RV32C-aware realigner: turns 32-bit fetch words into one 16- or 32-bit instruction
// per handshake, tracking the PC and handling halfword-aligned redirects and fetch errors.
module fetch_realigner #(
  parameter logic [31:0] BootAddr = 32'h0000_0080
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [31:0]        flush_pc_i,
  fetch_realigner_if.slave   bus
);

  localparam logic [1:0] MODE_ALIGNED = 2'd0;
  localparam logic [1:0] MODE_HOLD    = 2'd1;
  localparam logic [1:0] MODE_SKIP    = 2'd2;
  localparam logic [1:0] MODE_HALT    = 2'd3;

  logic [30:0] pc_q, pc_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_err_q, hold_err_d;
  logic [1:0]  mode_q, mode_d;

  logic        lo_comp;
  logic        hold_comp;
  logic        out_valid;
  logic        in_rdy;
  logic [31:0] instr;
  logic        comp;
  logic        err;
  logic        accept;
  logic        consume;
  logic [30:0] pc_inc;
  logic        unused_flush_pc_lsb;

  assign unused_flush_pc_lsb = flush_pc_i[0];

  // Output selection: never depends on out_rdy for out_valid.
  always_comb begin
    lo_comp   = bus.in_data[1:0] != 2'b11;
    hold_comp = hold_q[1:0] != 2'b11;
    out_valid = 1'b0;
    in_rdy    = 1'b0;
    instr     = bus.in_data;
    comp      = 1'b0;
    err       = bus.in_err;
    case (mode_q)
      MODE_ALIGNED: begin
        out_valid = bus.in_valid;
        in_rdy    = bus.out_rdy & bus.in_valid;
        if (lo_comp) begin
          instr = {16'h0000, bus.in_data[15:0]};
          comp  = 1'b1;
        end
      end
      MODE_HOLD: begin
        // An errored leftover halfword is released alone, without waiting for more data.
        if (hold_err_q || hold_comp) begin
          out_valid = 1'b1;
          instr     = {16'h0000, hold_q};
          comp      = 1'b1;
          err       = hold_err_q;
        end else begin
          out_valid = bus.in_valid;
          in_rdy    = bus.out_rdy & bus.in_valid;
          instr     = {bus.in_data[15:0], hold_q};
          err       = hold_err_q | bus.in_err;
        end
      end
      MODE_SKIP: begin
        in_rdy = bus.in_valid;
      end
      default: begin
      end
    endcase
    if (flush_i) begin
      out_valid = 1'b0;
      in_rdy    = 1'b0;
    end
  end

  always_comb begin
    accept     = out_valid & bus.out_rdy;
    consume    = bus.in_valid & in_rdy;
    pc_inc     = comp ? 31'd1 : 31'd2;
    pc_d       = pc_q;
    hold_d     = hold_q;
    hold_err_d = hold_err_q;
    mode_d     = mode_q;
    if (flush_i) begin
      pc_d       = flush_pc_i[31:1];
      hold_d     = 16'h0000;
      hold_err_d = 1'b0;
      mode_d     = flush_pc_i[1] ? MODE_SKIP : MODE_ALIGNED;
    end else begin
      // The upper half is captured on every consume; it is only read back in HOLD.
      if (consume) begin
        hold_d     = bus.in_data[31:16];
        hold_err_d = bus.in_err;
      end
      if (accept) begin
        pc_d = pc_q + pc_inc;
        if (err) begin
          mode_d = MODE_HALT;
        end else if (mode_q == MODE_ALIGNED) begin
          mode_d = lo_comp ? MODE_HOLD : MODE_ALIGNED;
        end else if (mode_q == MODE_HOLD) begin
          mode_d = hold_comp ? MODE_ALIGNED : MODE_HOLD;
        end
      end else if ((mode_q == MODE_SKIP) && consume) begin
        mode_d = MODE_HOLD;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q       <= BootAddr[31:1];
      hold_q     <= 16'h0000;
      hold_err_q <= 1'b0;
      mode_q     <= MODE_ALIGNED;
    end else begin
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      hold_err_q <= hold_err_d;
      mode_q     <= mode_d;
    end
  end

  assign bus.out_valid   = rst_ni & out_valid;
  assign bus.in_rdy      = rst_ni & in_rdy;
  assign bus.out_instr   = rst_ni ? instr : 32'h0000_0000;
  assign bus.out_pc      = rst_ni ? {pc_q, 1'b0} : 32'h0000_0000;
  assign bus.out_is_comp = rst_ni & comp;
  assign bus.out_err     = rst_ni & err;

endmodule
